// File: rtl/mac_feeder_pkg.sv
// Shared types and default sizing for the MAC lane feeder.
// Derived sizes here describe the default configuration; the top derives its own from its parameters.
package mac_feeder_pkg;

   typedef enum logic [1:0] {
      STREAM = 2'd0,
      FLUSH  = 2'd1,
      WAIT   = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam int DEF_LOG2_NO_VECS = 2;
   localparam int DEF_BW_IN        = 16;
   localparam int DEF_BW_W         = 2;
   localparam int DEF_BW_OUT       = 16;
   localparam int DEF_NUM_CYC      = 32;
   localparam int DEF_RES_LAT      = 4;

   localparam int NO_VECS = 1 << DEF_LOG2_NO_VECS;
   localparam int CNT_BW  = $clog2(DEF_NUM_CYC);
   localparam int WAIT_BW = $clog2(DEF_RES_LAT + 1);

endpackage

// File: rtl/mac_weight_ram.sv
// Per-beat weight store: one synchronous write port, one combinational read port.
// A same-cycle write and read of one address returns the old contents; no reset.
module mac_weight_ram #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mac_feeder.sv
// Feeds NUM_CYC-beat frames plus a closing flush beat into a MAC lane and returns one result per frame.
// Beats reach mac_* one cycle after acceptance; s_ready stays low from the last beat until the result handshake.
module mac_feeder
   import mac_feeder_pkg::*;
#(
   parameter int LOG2_NO_VECS = DEF_LOG2_NO_VECS,
   parameter int BW_IN        = DEF_BW_IN,
   parameter int BW_W         = DEF_BW_W,
   parameter int BW_OUT       = DEF_BW_OUT,
   parameter int NUM_CYC      = DEF_NUM_CYC,
   parameter int RES_LAT      = DEF_RES_LAT
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                w_we,
   input  logic [$clog2(NUM_CYC)-1:0]          w_addr,
   input  logic [(1<<LOG2_NO_VECS)*BW_W-1:0]   w_data,
   input  logic                                s_valid,
   output logic                                s_ready,
   input  logic [(1<<LOG2_NO_VECS)*BW_IN-1:0]  s_data,
   output logic [(1<<LOG2_NO_VECS)*BW_IN-1:0]  mac_data,
   output logic [(1<<LOG2_NO_VECS)*BW_W-1:0]   mac_w,
   output logic                                mac_new_sum,
   input  logic [BW_OUT-1:0]                   mac_result,
   output logic                                m_valid,
   input  logic                                m_ready,
   output logic [BW_OUT-1:0]                   m_data
);

   localparam int NV = 1 << LOG2_NO_VECS;
   localparam int CW = $clog2(NUM_CYC);
   localparam int WB = $clog2(RES_LAT + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_CYC - 1);

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic [WB-1:0]         wait_cnt, wait_nxt;
   logic [NV*BW_IN-1:0]   data_nxt;
   logic [NV*BW_W-1:0]    w_nxt, w_rd;
   logic                  ns_nxt, mv_nxt;
   logic [BW_OUT-1:0]     md_nxt;

   mac_weight_ram #(
      .DEPTH (NUM_CYC),
      .WIDTH (NV*BW_W)
   ) u_wram (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_addr),
      .wdata (w_data),
      .raddr (cnt),
      .rdata (w_rd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= STREAM;
         cnt         <= '0;
         wait_cnt    <= '0;
         mac_data    <= '0;
         mac_w       <= '0;
         mac_new_sum <= 1'b0;
         m_valid     <= 1'b0;
         m_data      <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         wait_cnt    <= wait_nxt;
         mac_data    <= data_nxt;
         mac_w       <= w_nxt;
         mac_new_sum <= ns_nxt;
         m_valid     <= mv_nxt;
         m_data      <= md_nxt;
      end
   end

   // Anything not explicitly driven defaults to a zero MAC input so idle cycles add nothing.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wait_nxt  = wait_cnt;
      data_nxt  = '0;
      w_nxt     = '0;
      ns_nxt    = 1'b0;
      mv_nxt    = m_valid;
      md_nxt    = m_data;
      s_ready   = 1'b0;
      case (state)
         STREAM: begin
            s_ready = 1'b1;
            if (s_valid) begin
               data_nxt = s_data;
               w_nxt    = w_rd;
               ns_nxt   = (cnt == '0);
               if (cnt == LAST_BEAT) begin
                  cnt_nxt   = '0;
                  state_nxt = FLUSH;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         FLUSH: begin
            ns_nxt    = 1'b1;
            wait_nxt  = WB'(RES_LAT);
            state_nxt = WAIT;
         end
         WAIT: begin
            if (wait_cnt == '0) begin
               md_nxt    = mac_result;
               mv_nxt    = 1'b1;
               state_nxt = HOLD;
            end else begin
               wait_nxt = wait_cnt - 1'b1;
            end
         end
         HOLD: begin
            if (m_ready) begin
               mv_nxt    = 1'b0;
               state_nxt = STREAM;
            end
         end
         default: state_nxt = STREAM;
      endcase
   end

endmodule
